// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: credit-limited word requests to imem, in-order
// response buffering in a FWFT FIFO, and redirect flush with stale-response drop.
module ifetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fpc;
  logic [31:0]   r_rpc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];

  logic [SW-1:0] w_used;
  logic          w_credit;
  logic          w_fire;
  logic          w_rsp_drop;
  logic          w_rsp_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_inst_valid;
  logic [31:0]   w_redir_pc;
  logic [1:0]    w_unused_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
  assign w_unused_lsbs = redirect_pc[1:0];

  // Dropped responses still hold a credit until they return.
  assign w_used   = SW'(r_out) + SW'(r_drop) + SW'(r_count);
  assign w_credit = w_used < SW'(DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fpc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign w_rsp_drop   = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_acc    = imem_rsp_valid && (r_drop == '0) && (r_out != '0);
  assign w_inst_valid = (r_count != '0);
  assign w_push       = w_rsp_acc && !redirect_valid;
  assign w_pop        = w_inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = w_inst_valid;
  assign inst       = w_inst_valid ? r_mem_inst[r_rptr] : NOP;
  assign inst_pc    = w_inst_valid ? r_mem_pc[r_rptr]   : r_rpc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc   <= RESET_ADDR;
      r_rpc   <= RESET_ADDR;
      r_out   <= '0;
      r_drop  <= '0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect_valid) begin
      // A response returning this cycle settles one outstanding slot either way.
      r_fpc   <= w_redir_pc;
      r_rpc   <= w_redir_pc;
      r_out   <= '0;
      r_drop  <= r_drop + r_out - CW'(w_rsp_drop || w_rsp_acc);
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_fire) r_fpc <= r_fpc + 32'd4;
      if (w_push) begin
        r_rpc  <= r_rpc + 32'd4;
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      if (w_rsp_drop) r_drop <= r_drop - 1'b1;
      r_out   <= r_out + CW'(w_fire) - CW'(w_rsp_acc);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= r_rpc;
      r_mem_inst[r_wptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: in-order memory model returning the address
// as data, consumed-instruction collector, hand-computed PC sequences.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_ADDR(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: responds in request order, 'lat' negedges after the request is seen.
  typedef struct {
    logic [31:0] a;
    int unsigned due;
  } req_t;
  req_t        memq[$];
  int unsigned ncnt   = 0;
  int unsigned lat    = 1;
  int unsigned n_fire = 0;

  always @(negedge clk) begin
    req_t r;
    ncnt++;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      memq.delete();
    end else begin
      if (memq.size() > 0 && memq[0].due <= ncnt) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memq[0].a;
        void'(memq.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        r.a   = imem_req_addr;
        r.due = ncnt + lat;
        memq.push_back(r);
        n_fire++;
      end
    end
  end

  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  always @(negedge clk) begin
    if (!rst && !redirect_valid && inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic collect(input int n);
    int k = 0;
    while (got_pc.size() < n && k < 300) begin
      step(1);
      k++;
    end
    chk("collect_count", 32'(got_pc.size() >= n), 32'd1);
  endtask

  task automatic expect_seq(input string tag, input logic [31:0] base, input int n);
    logic [31:0] p, d, e;
    for (int i = 0; i < n; i++) begin
      e = base + 32'(4 * i);
      if (got_pc.size() > 0) begin
        p = got_pc.pop_front();
        d = got_inst.pop_front();
      end else begin
        p = 'x;
        d = 'x;
      end
      chk($sformatf("%s_pc%0d", tag, i), p, e);
      chk($sformatf("%s_inst%0d", tag, i), d, e);
    end
  endtask

  task automatic do_redirect(input logic [31:0] a);
    got_pc.delete();
    got_inst.delete();
    redirect_pc    = a;
    redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  imem_req_addr, 32'h0000_0000);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},      inst, 32'h0000_0013);
    chk({tag, "_inst_pc"},   inst_pc, 32'h0000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int k;

    // Reset state and first fetch latency
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0000_0000);
    @(negedge clk);
    chk("valid_at_n1", 32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("valid_at_n2", 32'(inst_valid), 32'd1);
    chk("pc_at_n2", inst_pc, 32'h0000_0000);
    collect(8);
    expect_seq("stream", 32'h0000_0000, 8);

    // Backpressure: only DEPTH requests, then order preserved on release
    inst_ready = 1'b0;
    do_redirect(32'h0000_0400);
    base = n_fire;
    step(10);
    @(negedge clk);
    chk("bp_fires", 32'(n_fire - base), 32'd2);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_inst_valid", 32'(inst_valid), 32'd1);
    chk("bp_head_pc", inst_pc, 32'h0000_0400);
    step(1);
    inst_ready = 1'b1;
    collect(4);
    expect_seq("bp", 32'h0000_0400, 4);

    // Redirect with two requests in flight on a 3-cycle memory
    lat = 3;
    k = 0;
    while (memq.size() != 2 && k < 50) begin
      step(1);
      k++;
    end
    chk("inflight2", 32'(memq.size()), 32'd2);
    do_redirect(32'h0000_0100);
    @(negedge clk);
    chk("redir_valid_r1", 32'(inst_valid), 32'd0);
    chk("redir_addr_r1", imem_req_addr, 32'h0000_0100);
    collect(2);
    expect_seq("redir", 32'h0000_0100, 2);

    // Misaligned redirect target
    lat = 1;
    do_redirect(32'h0000_0203);
    @(negedge clk);
    chk("misal_req_addr", imem_req_addr, 32'h0000_0200);
    collect(1);
    expect_seq("misal", 32'h0000_0200, 1);

    // Address wrap
    do_redirect(32'hFFFF_FFF8);
    collect(3);
    expect_seq("wrap", 32'hFFFF_FFF8, 3);

    // Asynchronous reset between edges with a full FIFO
    inst_ready = 1'b0;
    do_redirect(32'h0000_0800);
    step(8);
    @(negedge clk);
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    chk("pre_rst_pc", inst_pc, 32'h0000_0800);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    step(2);
    rst = 1'b0;
    inst_ready = 1'b1;
    got_pc.delete();
    got_inst.delete();
    @(negedge clk);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0000_0000);
    collect(3);
    expect_seq("post_rst", 32'h0000_0000, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
